// File: rtl/iterative_vector_dot_product.sv
// Serial Q16.16 dot product (sum lhs[i]*rhs[i] + bias) on one shared multi-cycle FMA; result held until output_ready.
// Latency 1 + N*(1+T) cycles from the accept cycle to output_valid; input_ready low while busy, no queuing.

module slow_fp_fused_multiply_add #(
    parameter int latency = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        input_valid,
    output logic        input_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [1:0]  opcode,
    output logic        output_valid,
    output logic [31:0] r
);
    localparam int CW = (latency > 1) ? $clog2(latency + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_q, res_d;
    logic signed [63:0] prod, term, sum;
    logic [31:0]   sat;

    // opcode bit 0 negates the product, bit 1 negates the addend; product truncates toward -inf
    always_comb begin
        prod = 64'(signed'(a)) * 64'(signed'(b));
        term = prod >>> 16;
        if (opcode[0]) term = -term;
        sum = opcode[1] ? (term - 64'(signed'(c))) : (term + 64'(signed'(c)));
        if (sum > 64'sd2147483647)       sat = 32'h7fff_ffff;
        else if (sum < -64'sd2147483648) sat = 32'h8000_0000;
        else                             sat = sum[31:0];
    end

    assign input_ready  = (cnt_q == '0);
    assign output_valid = (cnt_q == CW'(1));
    assign r            = res_q;

    always_comb begin
        cnt_d = cnt_q;
        res_d = res_q;
        if (input_valid && input_ready) begin
            cnt_d = CW'(latency);
            res_d = sat;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end
endmodule

module iterative_vector_dot_product #(
    parameter int dimensions       = 3,
    parameter int multiply_latency = 32 / 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         input_valid,
    output logic                         input_ready,
    input  logic [dimensions*32-1:0]     lhs,
    input  logic [dimensions*32-1:0]     rhs,
    input  logic [31:0]                  bias,
    input  logic                         use_bias,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic [31:0]                  dot_product,
    output logic                         busy
);
    localparam int IDX_W = (dimensions > 1) ? $clog2(dimensions) : 1;
    localparam logic [1:0] FMA_OPCODE_POS_A_POS_C = 2'b00;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state_q, state_d;
    logic [dimensions-1:0][31:0] lhs_q, lhs_d, rhs_q, rhs_d;
    logic [31:0]      acc_q, acc_d, dot_q, dot_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic        fma_in_vld, fma_in_rdy, fma_out_vld;
    logic [31:0] fma_r;

    slow_fp_fused_multiply_add #(.latency(multiply_latency)) u_fma (
        .clock        (clock),
        .reset        (reset),
        .input_valid  (fma_in_vld),
        .input_ready  (fma_in_rdy),
        .a            (lhs_q[idx_q]),
        .b            (rhs_q[idx_q]),
        .c            (acc_q),
        .opcode       (FMA_OPCODE_POS_A_POS_C),
        .output_valid (fma_out_vld),
        .r            (fma_r)
    );

    always_comb begin
        state_d    = state_q;
        lhs_d      = lhs_q;
        rhs_d      = rhs_q;
        acc_d      = acc_q;
        dot_d      = dot_q;
        idx_d      = idx_q;
        fma_in_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (input_valid) begin
                    lhs_d   = lhs;
                    rhs_d   = rhs;
                    acc_d   = use_bias ? bias : 32'h0;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fma_in_vld = fma_in_rdy;
                if (fma_in_rdy) state_d = WAIT;
            end
            WAIT: begin
                // FMA results arriving in any other state are dropped
                if (fma_out_vld) begin
                    acc_d = fma_r;
                    if (idx_q == IDX_W'(dimensions - 1)) begin
                        dot_d   = fma_r;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                if (output_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lhs_q   <= '0;
            rhs_q   <= '0;
            acc_q   <= '0;
            dot_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            acc_q   <= acc_d;
            dot_q   <= dot_d;
            idx_q   <= idx_d;
        end
    end

    assign input_ready  = (state_q == IDLE);
    assign output_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign dot_product  = dot_q;
endmodule

// File: tb/tb_iterative_vector_dot_product.sv
// Directed and random checks of the serial dot product, N=3 and N=1 instances, Q16.16 values.
module tb_iterative_vector_dot_product;
    localparam int T = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        iv3, ir3, ov3, or3, ub3, busy3;
    logic [95:0] lhs3, rhs3;
    logic [31:0] bias3, dp3;

    logic        iv1, ir1, ov1, or1, ub1, busy1;
    logic [31:0] lhs1, rhs1, bias1, dp1;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    iterative_vector_dot_product #(.dimensions(3), .multiply_latency(T)) dut3 (
        .clock(clock), .reset(reset), .input_valid(iv3), .input_ready(ir3),
        .lhs(lhs3), .rhs(rhs3), .bias(bias3), .use_bias(ub3),
        .output_valid(ov3), .output_ready(or3), .dot_product(dp3), .busy(busy3));

    iterative_vector_dot_product #(.dimensions(1), .multiply_latency(T)) dut1 (
        .clock(clock), .reset(reset), .input_valid(iv1), .input_ready(ir1),
        .lhs(lhs1), .rhs(rhs1), .bias(bias1), .use_bias(ub1),
        .output_valid(ov1), .output_ready(or1), .dot_product(dp1), .busy(busy1));

    always @(posedge clock) if (iv3 && ir3) acc_cnt++;

    typedef struct {
        logic [31:0] l [3];
        logic [31:0] r [3];
        logic [31:0] bias;
        logic        ub;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [31:0] fx(input real v);
        return 32'($rtoi(v * 65536.0));
    endfunction

    function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        longint p, s;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 16;
        s = p + longint'($signed(c));
        if (s > 64'sd2147483647) return 32'h7fff_ffff;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    function automatic logic [31:0] rv();
        return 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run3(input logic [31:0] l [3], input logic [31:0] r [3], input logic [31:0] b,
                        input logic u, output logic [31:0] res, output int lat, output logic ok);
        int to = 0;
        lhs3 = {l[2], l[1], l[0]};
        rhs3 = {r[2], r[1], r[0]};
        bias3 = b;
        ub3 = u;
        while (!ir3 && to < 100) begin @(posedge clock); #1; to++; end
        iv3 = 1'b1;
        @(posedge clock); #1;
        iv3 = 1'b0;
        lat = 1;
        while (!ov3 && lat < 200) begin @(posedge clock); #1; lat++; end
        ok = ov3;
        res = dp3;
    endtask

    initial begin
        logic [31:0] res, held;
        logic [31:0] la [3], ra [3];
        logic ok;
        int lat, bad, to;
        logic [31:0] exp_q [$];

        tbl[0] = '{'{fx(1), fx(2), fx(3)}, '{fx(4), fx(5), fx(6)}, fx(0), 1'b0, fx(32)};
        tbl[1] = '{'{fx(1), fx(2), fx(3)}, '{fx(4), fx(5), fx(6)}, fx(-32), 1'b1, fx(0)};
        tbl[2] = '{'{fx(1), fx(2), fx(3)}, '{fx(4), fx(5), fx(6)}, fx(0.5), 1'b1, fx(32.5)};
        tbl[3] = '{'{fx(1), fx(1), fx(1)}, '{fx(2), fx(2), fx(2)}, fx(0), 1'b0, fx(6)};
        tbl[4] = '{'{fx(-1.5), fx(2), fx(0.25)}, '{fx(2), fx(-0.5), fx(8)}, fx(0), 1'b0, fx(-2)};
        tbl[5] = '{'{fx(0.5), fx(0.5), fx(0.5)}, '{fx(0.5), fx(0.5), fx(0.5)}, fx(7), 1'b0, fx(0.75)};

        reset = 1'b1;
        iv3 = 0; or3 = 1; ub3 = 0; lhs3 = '0; rhs3 = '0; bias3 = '0;
        iv1 = 0; or1 = 1; ub1 = 0; lhs1 = '0; rhs1 = '0; bias1 = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("reset input_ready", 32'(ir3), 32'd1);
        check("reset output_valid", 32'(ov3), 32'd0);
        check("reset busy", 32'(busy3), 32'd0);
        check("reset dot_product", dp3, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 6; i++) begin
            run3(tbl[i].l, tbl[i].r, tbl[i].bias, tbl[i].ub, res, lat, ok);
            check($sformatf("tbl%0d valid", i), 32'(ok), 32'd1);
            check($sformatf("tbl%0d result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d latency", i), 32'(lat), 32'(1 + 3 * (1 + T)));
            @(posedge clock); #1;
            check($sformatf("tbl%0d valid one cycle", i), 32'(ov3), 32'd0);
            check($sformatf("tbl%0d ready after handshake", i), 32'(ir3), 32'd1);
        end

        // result held under backpressure, requests during DONE ignored
        or3 = 1'b0;
        run3(tbl[0].l, tbl[0].r, tbl[0].bias, tbl[0].ub, res, lat, ok);
        check("hold result", res, fx(32));
        held = res;
        bad = 0;
        lhs3 = '0; rhs3 = '0;
        for (int k = 0; k < 10; k++) begin
            iv3 = k[0];
            @(posedge clock); #1;
            if (!ov3 || dp3 !== held || ir3) bad++;
        end
        iv3 = 1'b0;
        check("hold stable cycles bad", 32'(bad), 32'd0);
        or3 = 1'b1;
        @(posedge clock); #1;
        check("release output_valid", 32'(ov3), 32'd0);
        check("release input_ready", 32'(ir3), 32'd1);
        bad = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (ov3 || busy3) bad++;
        end
        check("no queued request", 32'(bad), 32'd0);

        // reset in WAIT of element 1
        lhs3 = {fx(3), fx(2), fx(1)};
        rhs3 = {fx(6), fx(5), fx(4)};
        ub3 = 1'b0;
        iv3 = 1'b1;
        @(posedge clock); #1;
        iv3 = 1'b0;
        repeat (T + 2) @(posedge clock);
        #1;
        check("busy before reset", 32'(busy3), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid reset output_valid", 32'(ov3), 32'd0);
        check("mid reset input_ready", 32'(ir3), 32'd1);
        check("mid reset busy", 32'(busy3), 32'd0);
        run3(tbl[3].l, tbl[3].r, tbl[3].bias, tbl[3].ub, res, lat, ok);
        check("after reset result", res, fx(6));
        check("after reset valid", 32'(ok), 32'd1);
        @(posedge clock); #1;

        // N=1 instance
        lhs1 = fx(-2.5); rhs1 = fx(4); ub1 = 1'b0; bias1 = fx(9);
        iv1 = 1'b1;
        @(posedge clock); #1;
        iv1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 200) begin @(posedge clock); #1; lat++; end
        check("n1 result", dp1, fx(-10));
        check("n1 latency", 32'(lat), 32'(2 + T));
        @(posedge clock); #1;
        check("n1 valid one cycle", 32'(ov1), 32'd0);

        // back-to-back random requests with input_valid held high
        acc_cnt = 0;
        iv3 = 1'b1;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    logic [31:0] e;
                    for (int j = 0; j < 3; j++) begin la[j] = rv(); ra[j] = rv(); end
                    lhs3 = {la[2], la[1], la[0]};
                    rhs3 = {ra[2], ra[1], ra[0]};
                    bias3 = rv();
                    ub3 = 1'($urandom_range(0, 1));
                    to = 0;
                    while (!ir3 && to < 200) begin @(posedge clock); #1; to++; end
                    if (!ir3) begin
                        check("rand accept timeout", 32'(ir3), 32'd1);
                        break;
                    end
                    e = ub3 ? bias3 : 32'h0;
                    for (int j = 0; j < 3; j++) e = fma_ref(la[j], ra[j], e);
                    exp_q.push_back(e);
                    @(posedge clock); #1;
                end
                iv3 = 1'b0;
            end
            begin
                int got = 0;
                int cyc = 0;
                while (got < 50 && cyc < 5000) begin
                    @(posedge clock); #1;
                    cyc++;
                    if (ov3) begin
                        if (exp_q.size() == 0) check($sformatf("rand%0d unexpected result", got), dp3, 32'hx);
                        else check($sformatf("rand%0d result", got), dp3, exp_q.pop_front());
                        got++;
                    end
                end
                check("rand result count", 32'(got), 32'd50);
            end
        join
        iv3 = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        check("rand accept count", 32'(acc_cnt), 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
